// File: rtl/reg_file_wb.sv
// Write-back stage and 32x32 general register file with one outstanding load,
// same-cycle read bypass and a combinational load-hazard stall.
module reg_file_wb #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  input  logic             we,
  input  logic [4:0]       rd_addr,
  input  logic [1:0]       wb_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] shift_result,
  input  logic [WIDTH-1:0] link_addr,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             stall,
  output logic             ld_pending
);

  localparam logic [1:0] SEL_ALU   = 2'd0;
  localparam logic [1:0] SEL_SHIFT = 2'd1;
  localparam logic [1:0] SEL_LINK  = 2'd2;
  localparam logic [1:0] SEL_LOAD  = 2'd3;

  logic [WIDTH-1:0] regs [NREG];
  logic             pend_valid_reg;
  logic [4:0]       pend_rd_reg;
  logic             pend_valid_next;
  logic [4:0]       pend_rd_next;

  logic             haz;
  logic             accept;
  logic             load_ret;
  logic             imm_wr;
  logic             new_load;
  logic [WIDTH-1:0] wb_data;
  logic [NREG-1:0]  wr_en;
  logic [WIDTH-1:0] wr_val [NREG];

  // pend_rd is never 0 while pend_valid is set, but the explicit nonzero
  // checks keep address-0 matches out of the hazard regardless.
  always_comb begin
    haz = 1'b0;
    if (pend_valid_reg && !ld_valid) begin
      if (rs_addr != 5'd0 && rs_addr == pend_rd_reg)
        haz = 1'b1;
      if (rt_addr != 5'd0 && rt_addr == pend_rd_reg)
        haz = 1'b1;
      if (we && rd_addr != 5'd0 && rd_addr == pend_rd_reg)
        haz = 1'b1;
      if (we && wb_sel == SEL_LOAD)
        haz = 1'b1;
    end
  end

  assign stall      = haz;
  assign ld_pending = pend_valid_reg;
  assign accept     = we && !haz;
  assign load_ret   = ld_valid && pend_valid_reg;
  assign imm_wr     = accept && (wb_sel != SEL_LOAD) && (rd_addr != 5'd0);
  assign new_load   = accept && (wb_sel == SEL_LOAD) && (rd_addr != 5'd0);

  always_comb begin
    wb_data = alu_result;
    case (wb_sel)
      SEL_ALU:   wb_data = alu_result;
      SEL_SHIFT: wb_data = shift_result;
      SEL_LINK:  wb_data = link_addr;
      default:   wb_data = alu_result;
    endcase
  end

  // Per-register write decode; the younger immediate write beats a returning load.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wr
      if (gi == 0) begin : g_zero
        assign wr_en[gi]  = 1'b0;
        assign wr_val[gi] = '0;
      end else begin : g_reg
        logic imm_hit;
        logic ld_hit;
        assign imm_hit    = imm_wr && (rd_addr == 5'(gi));
        assign ld_hit     = load_ret && (pend_rd_reg == 5'(gi));
        assign wr_en[gi]  = imm_hit || ld_hit;
        assign wr_val[gi] = imm_hit ? wb_data : ld_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (wr_en[i])
          regs[i] <= wr_val[i];
    end
  end

  // A newly accepted load overrides the clear from a load returning the same cycle.
  always_comb begin
    pend_valid_next = pend_valid_reg;
    pend_rd_next    = pend_rd_reg;
    if (load_ret)
      pend_valid_next = 1'b0;
    if (new_load) begin
      pend_valid_next = 1'b1;
      pend_rd_next    = rd_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_rd_reg    <= 5'd0;
    end else begin
      pend_valid_reg <= pend_valid_next;
      pend_rd_reg    <= pend_rd_next;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [4:0] addr);
    logic [WIDTH-1:0] val;
    val = regs[addr];
    if (addr == 5'd0)
      val = '0;
    else if (load_ret && addr == pend_rd_reg)
      val = ld_data;
    else if (imm_wr && addr == rd_addr)
      val = wb_data;
    return val;
  endfunction

  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: write/read, bypass, load-use stall,
// second load, WAW, load/write collision and reset during a pending load.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic        we;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result, shift_result, link_addr;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        stall, ld_pending;

  int total = 0;
  int bad   = 0;

  reg_file_wb #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .we(we), .rd_addr(rd_addr), .wb_sel(wb_sel),
    .alu_result(alu_result), .shift_result(shift_result), .link_addr(link_addr),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .stall(stall), .ld_pending(ld_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; rd_addr = 5'd0; wb_sel = 2'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    ld_valid = 1'b0; ld_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    alu_result = '0; shift_result = '0; link_addr = '0;
    rs_addr = 5'd5; rt_addr = 5'd31;
    #3;
    total++; if (rs_data !== 32'h0) begin bad++; $display("FAIL rst_rs got=%h exp=%h", rs_data, 32'h0); end else $display("ok   rst_rs");
    total++; if (rt_data !== 32'h0) begin bad++; $display("FAIL rst_rt got=%h exp=%h", rt_data, 32'h0); end else $display("ok   rst_rt");
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end else $display("ok   rst_stall");
    total++; if (ld_pending !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b exp=0", ld_pending); end else $display("ok   rst_pending");
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_write_read();
    we = 1'b1; rd_addr = 5'd5; wb_sel = 2'd0;
    alu_result = 32'h12345678; shift_result = 32'hAAAAAAAA; link_addr = 32'hBBBBBBBB;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL wr5_stall got=%b exp=0", stall); end else $display("ok   wr5_stall");
    next_cycle();
    we = 1'b0; rs_addr = 5'd5;
    #2;
    total++; if (rs_data !== 32'h12345678) begin bad++; $display("FAIL rd5 got=%h exp=%h", rs_data, 32'h12345678); end else $display("ok   rd5");
    we = 1'b1; rd_addr = 5'd0; wb_sel = 2'd1; shift_result = 32'hFFFF0000; rt_addr = 5'd0;
    #2;
    total++; if (rt_data !== 32'h0) begin bad++; $display("FAIL wr0_bypass got=%h exp=%h", rt_data, 32'h0); end else $display("ok   wr0_bypass");
    total++; if (rs_data !== 32'h12345678) begin bad++; $display("FAIL rd5_during_wr0 got=%h exp=%h", rs_data, 32'h12345678); end else $display("ok   rd5_during_wr0");
    next_cycle();
    we = 1'b0;
    #2;
    total++; if (rt_data !== 32'h0) begin bad++; $display("FAIL rd0 got=%h exp=%h", rt_data, 32'h0); end else $display("ok   rd0");
    next_cycle();
  endtask

  task automatic test_bypass();
    we = 1'b1; rd_addr = 5'd31; wb_sel = 2'd2;
    link_addr = 32'h00400008; alu_result = 32'h11; shift_result = 32'h22;
    rs_addr = 5'd31; rt_addr = 5'd5;
    #2;
    total++; if (rs_data !== 32'h00400008) begin bad++; $display("FAIL link_bypass got=%h exp=%h", rs_data, 32'h00400008); end else $display("ok   link_bypass");
    total++; if (rt_data !== 32'h12345678) begin bad++; $display("FAIL other_port got=%h exp=%h", rt_data, 32'h12345678); end else $display("ok   other_port");
    next_cycle();
    we = 1'b0; link_addr = 32'h0; alu_result = 32'h33;
    #2;
    total++; if (rs_data !== 32'h00400008) begin bad++; $display("FAIL rd31 got=%h exp=%h", rs_data, 32'h00400008); end else $display("ok   rd31");
    next_cycle();
  endtask

  task automatic test_load_use();
    idle_inputs();
    we = 1'b1; wb_sel = 2'd3; rd_addr = 5'd8;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld8_issue_stall got=%b exp=0", stall); end else $display("ok   ld8_issue_stall");
    next_cycle();
    we = 1'b1; wb_sel = 2'd0; rd_addr = 5'd10; alu_result = 32'h55;
    rt_addr = 5'd8; rs_addr = 5'd10;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL use_stall[%0d] got=%b exp=1", c, stall); end else $display("ok   use_stall[%0d]", c);
      total++; if (rs_data !== 32'h0) begin bad++; $display("FAIL stalled_no_bypass[%0d] got=%h exp=%h", c, rs_data, 32'h0); end else $display("ok   stalled_no_bypass[%0d]", c);
      total++; if (ld_pending !== 1'b1) begin bad++; $display("FAIL use_pending[%0d] got=%b exp=1", c, ld_pending); end else $display("ok   use_pending[%0d]", c);
      next_cycle();
    end
    ld_valid = 1'b1; ld_data = 32'hCAFEBABE;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ret_stall got=%b exp=0", stall); end else $display("ok   ret_stall");
    total++; if (rt_data !== 32'hCAFEBABE) begin bad++; $display("FAIL ret_fwd got=%h exp=%h", rt_data, 32'hCAFEBABE); end else $display("ok   ret_fwd");
    total++; if (rs_data !== 32'h55) begin bad++; $display("FAIL ret_imm_bypass got=%h exp=%h", rs_data, 32'h55); end else $display("ok   ret_imm_bypass");
    next_cycle();
    idle_inputs();
    rs_addr = 5'd8; rt_addr = 5'd10;
    #2;
    total++; if (ld_pending !== 1'b0) begin bad++; $display("FAIL ret_pending got=%b exp=0", ld_pending); end else $display("ok   ret_pending");
    total++; if (rs_data !== 32'hCAFEBABE) begin bad++; $display("FAIL r8_after got=%h exp=%h", rs_data, 32'hCAFEBABE); end else $display("ok   r8_after");
    total++; if (rt_data !== 32'h55) begin bad++; $display("FAIL r10_after got=%h exp=%h", rt_data, 32'h55); end else $display("ok   r10_after");
    next_cycle();
  endtask

  task automatic test_second_load();
    idle_inputs();
    we = 1'b1; wb_sel = 2'd3; rd_addr = 5'd8;
    next_cycle();
    rd_addr = 5'd9;
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld2_stall got=%b exp=1", stall); end else $display("ok   ld2_stall");
    next_cycle();
    ld_valid = 1'b1; ld_data = 32'h11111111;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld2_ret_stall got=%b exp=0", stall); end else $display("ok   ld2_ret_stall");
    next_cycle();
    idle_inputs();
    rs_addr = 5'd8;
    #2;
    total++; if (ld_pending !== 1'b1) begin bad++; $display("FAIL ld9_pending got=%b exp=1", ld_pending); end else $display("ok   ld9_pending");
    total++; if (rs_data !== 32'h11111111) begin bad++; $display("FAIL r8_ld got=%h exp=%h", rs_data, 32'h11111111); end else $display("ok   r8_ld");
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r8_free got=%b exp=0", stall); end else $display("ok   r8_free");
    rt_addr = 5'd9;
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL pend_rd9 got=%b exp=1", stall); end else $display("ok   pend_rd9");
    rt_addr = 5'd0; we = 1'b1; wb_sel = 2'd0; rd_addr = 5'd9; alu_result = 32'h3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw9 got=%b exp=1", stall); end else $display("ok   waw9");
    next_cycle();
    idle_inputs();
    ld_valid = 1'b1; ld_data = 32'h99999999; rs_addr = 5'd9;
    #2;
    total++; if (rs_data !== 32'h99999999) begin bad++; $display("FAIL r9_fwd got=%h exp=%h", rs_data, 32'h99999999); end else $display("ok   r9_fwd");
    next_cycle();
    ld_valid = 1'b0;
    #2;
    total++; if (ld_pending !== 1'b0) begin bad++; $display("FAIL r9_pending got=%b exp=0", ld_pending); end else $display("ok   r9_pending");
    total++; if (rs_data !== 32'h99999999) begin bad++; $display("FAIL r9_after got=%h exp=%h", rs_data, 32'h99999999); end else $display("ok   r9_after");
    next_cycle();
  endtask

  task automatic test_collision();
    idle_inputs();
    we = 1'b1; wb_sel = 2'd3; rd_addr = 5'd8;
    next_cycle();
    wb_sel = 2'd0; alu_result = 32'h2;
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw8 got=%b exp=1", stall); end else $display("ok   waw8");
    next_cycle();
    ld_valid = 1'b1; ld_data = 32'h1; rs_addr = 5'd8;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL coll_stall got=%b exp=0", stall); end else $display("ok   coll_stall");
    total++; if (rs_data !== 32'h1) begin bad++; $display("FAIL coll_fwd got=%h exp=%h", rs_data, 32'h1); end else $display("ok   coll_fwd");
    next_cycle();
    we = 1'b0; ld_data = 32'h77777777;
    #2;
    total++; if (rs_data !== 32'h2) begin bad++; $display("FAIL coll_r8 got=%h exp=%h", rs_data, 32'h2); end else $display("ok   coll_r8");
    total++; if (ld_pending !== 1'b0) begin bad++; $display("FAIL coll_pending got=%b exp=0", ld_pending); end else $display("ok   coll_pending");
    next_cycle();
    ld_valid = 1'b0;
    #2;
    total++; if (rs_data !== 32'h2) begin bad++; $display("FAIL stray_ld got=%h exp=%h", rs_data, 32'h2); end else $display("ok   stray_ld");
    next_cycle();
  endtask

  task automatic test_reset_mid_load();
    idle_inputs();
    we = 1'b1; wb_sel = 2'd3; rd_addr = 5'd4;
    next_cycle();
    idle_inputs();
    rs_addr = 5'd5; rt_addr = 5'd4;
    #2;
    total++; if (ld_pending !== 1'b1) begin bad++; $display("FAIL ld4_pending got=%b exp=1", ld_pending); end else $display("ok   ld4_pending");
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld4_stall got=%b exp=1", stall); end else $display("ok   ld4_stall");
    total++; if (rs_data !== 32'h12345678) begin bad++; $display("FAIL pre_rst_r5 got=%h exp=%h", rs_data, 32'h12345678); end else $display("ok   pre_rst_r5");
    rst = 1'b1;
    #1;
    total++; if (rs_data !== 32'h0) begin bad++; $display("FAIL mid_rst_r5 got=%h exp=%h", rs_data, 32'h0); end else $display("ok   mid_rst_r5");
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%b exp=0", stall); end else $display("ok   mid_rst_stall");
    total++; if (ld_pending !== 1'b0) begin bad++; $display("FAIL mid_rst_pending got=%b exp=0", ld_pending); end else $display("ok   mid_rst_pending");
    rt_addr = 5'd31;
    #1;
    total++; if (rt_data !== 32'h0) begin bad++; $display("FAIL mid_rst_r31 got=%h exp=%h", rt_data, 32'h0); end else $display("ok   mid_rst_r31");
    rst = 1'b0;
    next_cycle();
    ld_valid = 1'b1; ld_data = 32'h0000DEAD; rs_addr = 5'd4; rt_addr = 5'd4;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dead_stall got=%b exp=0", stall); end else $display("ok   dead_stall");
    total++; if (rs_data !== 32'h0) begin bad++; $display("FAIL dead_fwd got=%h exp=%h", rs_data, 32'h0); end else $display("ok   dead_fwd");
    next_cycle();
    ld_valid = 1'b0;
    #2;
    total++; if (rt_data !== 32'h0) begin bad++; $display("FAIL r4_after got=%h exp=%h", rt_data, 32'h0); end else $display("ok   r4_after");
    total++; if (ld_pending !== 1'b0) begin bad++; $display("FAIL dead_pending got=%b exp=0", ld_pending); end else $display("ok   dead_pending");
    next_cycle();
    we = 1'b1; wb_sel = 2'd3; rd_addr = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld0_stall got=%b exp=0", stall); end else $display("ok   ld0_stall");
    next_cycle();
    we = 1'b0;
    #2;
    total++; if (ld_pending !== 1'b0) begin bad++; $display("FAIL ld0_pending got=%b exp=0", ld_pending); end else $display("ok   ld0_pending");
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_load_use();
    test_second_load();
    test_collision();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Write-back stage and register file for the single-cycle CPU. Consumes the shifter result, the ALU result and the link address through a write-back select and commits them to the 32×32 general register file in the same cycle. Accepts one outstanding load whose data returns on later cycles, and produces the `rs`/`rt` read operands with same-cycle bypass. Raises `stall` on any hazard against the pending load.

## Interface
Parameters:
- `WIDTH`, 32: data width.
- `NREG`, 32: number of registers; register 0 is hardwired to zero.

Ports:
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rs_addr` input 5: read port A address (instr[25:21]).
- `rt_addr` input 5: read port B address (instr[20:16]).
- `rs_data` output WIDTH: read port A data, combinational.
- `rt_data` output WIDTH: read port B data, combinational.
- `we` input 1: current instruction writes a register.
- `rd_addr` input 5: destination register.
- `wb_sel` input 2: write-back source.
  - 0: `alu_result`.
  - 1: `shift_result`.
  - 2: `link_addr`.
  - 3: deferred load.
- `alu_result` input WIDTH: ALU output.
- `shift_result` input WIDTH: shifter output.
- `link_addr` input WIDTH: PC+4 for link instructions.
- `ld_valid` input 1: load data returning this cycle.
- `ld_data` input WIDTH: returned load data.
- `stall` output 1: current instruction not accepted; the PC must hold.
- `ld_pending` output 1: one load outstanding.

## Operation
State:
- `regs[1..NREG-1]`.
- `pend_valid`, `pend_rd[4:0]`.

Hazard (`haz`) is true when `pend_valid` is set, `ld_valid` is low, and any of the following holds:
- `rs_addr` == `pend_rd`.
- `rt_addr` == `pend_rd`.
- `we` is high and `rd_addr` == `pend_rd` (WAW).
- `we` is high and `wb_sel` == 3 (second load).

`stall` = `haz`. Matches on address 0 never cause a hazard.

Accepted instruction: `we` && !`stall`.
- `wb_sel` 0–2: writes `regs[rd_addr]` with the selected source at the clock edge.
- `wb_sel` 3: sets `pend_valid` and captures `pend_rd`. No data is written.

Load return: when `ld_valid` && `pend_valid`, the edge writes `regs[pend_rd]` with `ld_data` and clears `pend_valid`.
- `ld_valid` while `pend_valid` is low is ignored.

Simultaneous events in one cycle:
- Load return plus an accepted immediate write to the same register: the immediate write (younger) wins the register value, and `pend_valid` still clears.
- Load return plus acceptance of a new load: the old load completes and the new load is captured. The new pending entry takes precedence over the clear.

Writes to address 0, whether immediate or load, are discarded. A load with `rd_addr`=0 is accepted but does not set `pend_valid`.

Read bypass, priority highest first:
1. Address 0 reads 0.
2. `ld_valid` && `pend_valid` && address == `pend_rd` reads `ld_data`.
3. Accepted immediate write with `wb_sel` != 3 && address == `rd_addr` reads the selected write data.
4. Otherwise reads `regs[addr]`.

## Timing
- Reads are combinational. Write data is visible via the array on the cycle after the edge and via bypass in the same cycle.
- Load-use penalty: a dependent instruction stalls every cycle until the cycle `ld_valid` is high, and proceeds in that cycle using forwarded data.
- `stall` is combinational from inputs and `pend_*`, with no registered delay.
- Reset (async, any time):
  - All `regs` clear to 0.
  - `pend_valid` clears to 0 and `pend_rd` to 0.
  - `ld_pending` reads 0 and `stall` reads 0.
  - Reset mid-load drops the outstanding load. A later `ld_valid` is ignored.
- `ld_pending` = `pend_valid` (registered).

## Test plan
- Reset and write/read:
  - Write `alu_result`=0x12345678 to r5 (`wb_sel`=0). The next cycle, `rs_addr`=5 reads 0x12345678.
  - Write `shift_result`=0xFFFF0000 to r0. `rt_addr`=0 reads 0.
  - Assert `rst` mid-cycle. All reads return 0 immediately.
- Bypass: in the same cycle as writing `link_addr`=0x00400008 to r31 (`wb_sel`=2), `rs_addr`=31 reads 0x00400008.
- Load-use stall:
  - Issue a load to r8. The next instruction reads `rt_addr`=8, and `stall`=1 for 3 cycles.
  - Drive `ld_valid` with `ld_data`=0xCAFEBABE. In that cycle `stall`=0 and `rt_data`=0xCAFEBABE, and `ld_pending` then drops to 0.
- Second load and WAW:
  - Load to r8 is pending. A load to r9 stalls until `ld_valid`. On that cycle r8 gets `ld_data` and `pend_rd` becomes 9.
  - A write to r8 while r8 is pending stalls.
- Collision: `ld_valid` for r8 (data 0x1) in the same cycle an accepted ALU write to r8 (0x2). r8 reads 0x2 afterwards and `ld_pending`=0.
- Reset mid-load: load to r4 pending, pulse `rst`, then `ld_valid` with 0xDEAD. r4 stays 0 and `stall` stays 0.
